// File: rtl/cpu_load_pkg.sv
// rtl/cpu_load_pkg.sv - shared states, header constants and sizing helper for the UART loader
package cpu_load_pkg;

  typedef enum logic [1:0] {IDLE, ADDR, COUNT, DATA} state_e;

  // Load header is 1 h 0 0 tttt; with h masked, bits 7:6 read as this mark.
  localparam logic [1:0] HDR_LOAD_MARK = 2'b10;
  localparam logic [7:0] HDR_RUN       = 8'h3C;

  function automatic int addr_bytes(input int addr_w);
    return (addr_w + 7) / 8;
  endfunction

endpackage

// File: rtl/load_word_packer.sv
// rtl/load_word_packer.sv - MSB-first byte-to-word shift register with byte index
module load_word_packer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o
);

  localparam int WORD_BYTES = DATA_W / 8;
  localparam int IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int SH_W       = (DATA_W > 8) ? DATA_W - 8 : 1;

  logic [SH_W-1:0]  shift_q;
  logic [IDX_W-1:0] idx_q;

  // The completed word is presented in the cycle its last byte arrives.
  assign word_o       = DATA_W'({shift_q, byte_i});
  assign word_valid_o = byte_valid_i && !clear_i && (idx_q == IDX_W'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      idx_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= SH_W'({shift_q, byte_i});
      idx_q   <= word_valid_o ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_load_ctrl.sv
// rtl/cpu_load_ctrl.sv - framed UART program/data loader with CPU stall and timeout abort
module cpu_load_ctrl
  import cpu_load_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int NUM_TGT     = 2,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_valid,
  input  logic [7:0]         rx_byte,
  output logic [NUM_TGT-1:0] wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [DATA_W-1:0]  wr_data,
  output logic               cpu_hold,
  output logic               busy,
  output logic               load_done,
  output logic               err
);

  localparam int ADDR_BYTES = addr_bytes(ADDR_W);
  localparam int AB_W       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  localparam int TO_W       = $clog2(TIMEOUT_CYC + 1);

  state_e             state_q, state_d;
  logic [3:0]         tgt_q, tgt_d;
  logic               keep_q, keep_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [AB_W-1:0]    ab_q, ab_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [TO_W-1:0]    to_q, to_d;
  logic               hold_q, hold_d;
  logic               busy_q, busy_d;
  logic [NUM_TGT-1:0] we_q, we_d;
  logic [ADDR_W-1:0]  wa_q, wa_d;
  logic [DATA_W-1:0]  wd_q, wd_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               pk_clear, pk_valid_in, pk_valid;
  logic [DATA_W-1:0]  pk_word;
  logic               is_load, tgt_ok, timeout;

  assign pk_clear    = (state_q != DATA);
  assign pk_valid_in = rx_valid && (state_q == DATA);

  load_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pk_clear),
    .byte_valid_i (pk_valid_in),
    .byte_i       (rx_byte),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

  assign is_load = ((rx_byte[7:6] & 2'b10) == HDR_LOAD_MARK) && (rx_byte[5:4] == 2'b00);
  assign tgt_ok  = ({1'b0, rx_byte[3:0]} < 5'(NUM_TGT));
  // A byte arriving in the expiry cycle wins, so expiry requires no rx_valid.
  assign timeout = (state_q != IDLE) && !rx_valid && (to_q == TO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    keep_d  = keep_q;
    addr_d  = addr_q;
    ab_d    = ab_q;
    wcnt_d  = wcnt_q;
    to_d    = '0;
    hold_d  = hold_q;
    we_d    = '0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q != IDLE && !rx_valid) begin
      to_d = to_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          if (rx_byte == HDR_RUN) begin
            hold_d = 1'b0;
          end else if (is_load && tgt_ok) begin
            state_d = ADDR;
            tgt_d   = rx_byte[3:0];
            keep_d  = rx_byte[6];
            hold_d  = 1'b1;
            addr_d  = '0;
            ab_d    = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (rx_valid) begin
          addr_d = ADDR_W'({addr_q, rx_byte});
          if (ab_q == AB_W'(ADDR_BYTES - 1)) begin
            state_d = COUNT;
          end else begin
            ab_d = ab_q + 1'b1;
          end
        end
      end
      COUNT: begin
        if (rx_valid) begin
          wcnt_d  = rx_byte;
          state_d = DATA;
        end
      end
      DATA: begin
        if (pk_valid) begin
          we_d   = NUM_TGT'(1) << tgt_q;
          wa_d   = addr_q;
          wd_d   = pk_word;
          addr_d = addr_q + 1'b1;
          if (wcnt_q == 8'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (!keep_q) hold_d = 1'b0;
          end else begin
            wcnt_d = wcnt_q - 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
      hold_d  = 1'b0;
      to_d    = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      keep_q  <= 1'b0;
      addr_q  <= '0;
      ab_q    <= '0;
      wcnt_q  <= '0;
      to_q    <= '0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      we_q    <= '0;
      wa_q    <= '0;
      wd_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      keep_q  <= keep_d;
      addr_q  <= addr_d;
      ab_q    <= ab_d;
      wcnt_q  <= wcnt_d;
      to_q    <= to_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_en     = we_q;
  assign wr_addr   = wa_q;
  assign wr_data   = wd_q;
  assign cpu_hold  = hold_q;
  assign busy      = busy_q;
  assign load_done = done_q;
  assign err       = err_q;

endmodule
